ts_split_ram_w32r128: RTL and testbench
=======================================

// Module: ts_split_ram_w32r128
// PURPOSE
//  Asymmetric simple-dual-port RAM for the TS split/merge path: 32-bit words
//  written on port A, read back as 128-bit words on port B (4:1 aspect ratio).
//  Capacity 1 Mbit (32768 x 32 = 8192 x 128). Sits between the TS packet writer
//  and the PCIe-side reader, which byte-swaps each 32-bit lane downstream.
// PARAMETERS
//  AW_A   15   port A address width (words of DW_A)
//  DW_A   32   port A write data width
//  AW_B   13   port B address width (words of DW_B); AW_B = AW_A - log2(DW_B/DW_A)
//  DW_B   128  port B read data width; must be DW_A*4
// PORTS
//  clk    in   1      single clock for both ports (rising edge)
//  rst_n  in   1      asynchronous, active-low reset
//  wea    in   1      port A write enable
//  addra  in   AW_A   port A word address
//  dina   in   DW_A   port A write data
//  addrb  in   AW_B   port B word address
//  doutb  out  DW_B   port B read data (registered)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n), clock is clk.
//  - Reset: doutb clears to 0 immediately on rst_n low, held 0 while low.
//    Memory contents are NOT cleared by reset; power-up/sim init value is 0.
//  - Writes ignored while rst_n is low.
//  - Write: on rising clk with wea=1, dina stored at 32-bit slot addra.
//    Slot mapping: row = addra[AW_A-1:2], lane = addra[1:0];
//    lane 0 -> row bits [127:96], lane 1 -> [95:64], lane 2 -> [63:32],
//    lane 3 -> [31:0] (lowest narrow address in MSBs, big-endian lane order).
//    Only the addressed 32-bit lane changes; other lanes of the row keep value.
//  - Read: addrb sampled on rising clk; doutb = mem[addrb] valid after that
//    edge (1-cycle latency, no extra output register). No read enable: port B
//    reads every cycle.
//  - Collision (write row == addrb row on same edge): read-first; doutb shows
//    the row contents before the write; new data visible on the next read.
//  - Full address decode: all 32768/8192 addresses valid; no wrap or overflow
//    logic; addra=32767 maps to row 8191 bits [31:0].
//  - Implementation: inferable block RAM (e.g. 4 x 8192x32 lane banks with
//    lane-decoded write enables, concatenated on read), no vendor primitives.
// TESTING
//  1. Reset: rst_n=0 mid-operation with doutb nonzero -> doutb=0 at once,
//     stays 0 until first clk after rst_n=1.
//  2. Burst write wea=1, addra 0..3, dina 11223344,55667788,99aabbcc,
//     ddeeff00; then addrb=0 -> doutb=128'h11223344_55667788_99aabbcc_ddeeff00
//     one cycle after addrb sampled.
//  3. Partial lane update: then write addra=2 dina=cafebabe -> addrb=0 reads
//     128'h11223344_55667788_cafebabe_ddeeff00.
//  4. wea=0 with addra=4 dina=ffffffff -> addrb=1 reads 0 (untouched).
//  5. Top boundary: write addra=32767 dina=a5a5a5a5 -> addrb=8191 reads
//     128'h00000000_00000000_00000000_a5a5a5a5; addrb=0 unchanged.
//  6. Collision: addrb=0 and write addra=0 dina=deadbeef same edge -> doutb
//     old row (11223344 in MSBs); next cycle doutb[127:96]=deadbeef.

Source files
------------

// File: rtl/ts_split_ram_w32r128.sv
// Asymmetric simple-dual-port RAM: 32-bit writes on A, 128-bit reads on B (4:1), 1 Mbit total.
// Read latency 1 cycle, read-first on row collision; no backpressure, both ports accept every cycle.
module ts_split_ram_w32r128 #(
   parameter int AW_A = 15,
   parameter int DW_A = 32,
   parameter int AW_B = 13,
   parameter int DW_B = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wea,
   input  logic [AW_A-1:0] addra,
   input  logic [DW_A-1:0] dina,
   input  logic [AW_B-1:0] addrb,
   output logic [DW_B-1:0] doutb
);

   localparam int LANES   = DW_B / DW_A;
   localparam int LW      = $clog2(LANES);
   localparam int DEPTH_B = 1 << AW_B;

   logic [AW_B-1:0] row_a;
   logic [LW-1:0]   lane_a;

   assign row_a  = addra[AW_A-1:LW];
   assign lane_a = addra[LW-1:0];

   // One narrow bank per lane; lane 0 (lowest narrow address) lands in the MSBs.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DW_A-1:0] mem [0:DEPTH_B-1];
      logic [DW_A-1:0] rd;
      logic            we;

      assign we = wea & rst_n & (lane_a == LW'(l));

      always_ff @(posedge clk) begin
         if (we) begin
            mem[row_a] <= dina;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd <= '0;
         end else begin
            rd <= mem[addrb];
         end
      end

      assign doutb[(LANES-1-l)*DW_A +: DW_A] = rd;
   end

endmodule

// File: tb/tb_ts_split_ram_w32r128.sv
// Bench for ts_split_ram_w32r128: directed scenarios plus random traffic against a
// narrow-word array model that assembles 128-bit rows from four consecutive 32-bit slots.
module tb_ts_split_ram_w32r128;

   logic         clk;
   logic         rst_n;
   logic         wea;
   logic [14:0]  addra;
   logic [31:0]  dina;
   logic [12:0]  addrb;
   logic [127:0] doutb;

   int total;
   int bad;

   logic [31:0]  m [0:32767];
   logic [127:0] exp_d;

   ts_split_ram_w32r128 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .addrb (addrb),
      .doutb (doutb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [127:0] row_of(input logic [12:0] r);
      return {m[{r, 2'd0}], m[{r, 2'd1}], m[{r, 2'd2}], m[{r, 2'd3}]};
   endfunction

   // One clock edge with the model: read sees the row before this edge's write.
   task automatic tick();
      exp_d = row_of(addrb);
      if (wea && rst_n) m[addra] = dina;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wea   = 1'b0;
      addra = '0;
      dina  = '0;
      addrb = '0;
      for (int i = 0; i < 32768; i++) m[i] = 32'h0;
      @(posedge clk);
      #1;
      total++;
      if (doutb !== 128'h0) begin
         bad++;
         $display("FAIL reset_initial doutb=%h expected=%h", doutb, 128'h0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      wea = 1'b1;
      for (int i = 0; i < 32768; i++) begin
         addra = 15'(i);
         dina  = 32'h0;
         tick();
      end
      wea = 1'b0;
   endtask

   task automatic test_burst();
      logic [31:0] pat [0:3];
      pat[0] = 32'h11223344;
      pat[1] = 32'h55667788;
      pat[2] = 32'h99aabbcc;
      pat[3] = 32'hddeeff00;
      addrb = 13'd0;
      wea   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addra = 15'(i);
         dina  = pat[i];
         tick();
      end
      wea = 1'b0;
      tick();
      total++;
      if (doutb !== 128'h11223344_55667788_99aabbcc_ddeeff00) begin
         bad++;
         $display("FAIL burst_row0 doutb=%h expected=%h", doutb, 128'h11223344_55667788_99aabbcc_ddeeff00);
      end
   endtask

   task automatic test_partial_lane();
      wea   = 1'b1;
      addra = 15'd2;
      dina  = 32'hcafebabe;
      tick();
      wea = 1'b0;
      tick();
      total++;
      if (doutb !== 128'h11223344_55667788_cafebabe_ddeeff00) begin
         bad++;
         $display("FAIL partial_lane doutb=%h expected=%h", doutb, 128'h11223344_55667788_cafebabe_ddeeff00);
      end
   endtask

   task automatic test_wea_low();
      wea   = 1'b0;
      addra = 15'd4;
      dina  = 32'hffffffff;
      addrb = 13'd1;
      tick();
      tick();
      total++;
      if (doutb !== 128'h0) begin
         bad++;
         $display("FAIL wea_low_row1 doutb=%h expected=%h", doutb, 128'h0);
      end
   endtask

   task automatic test_top_boundary();
      wea   = 1'b1;
      addra = 15'd32767;
      dina  = 32'ha5a5a5a5;
      tick();
      wea   = 1'b0;
      addrb = 13'd8191;
      tick();
      total++;
      if (doutb !== 128'h00000000_00000000_00000000_a5a5a5a5) begin
         bad++;
         $display("FAIL top_row8191 doutb=%h expected=%h", doutb, 128'h00000000_00000000_00000000_a5a5a5a5);
      end
      addrb = 13'd0;
      tick();
      total++;
      if (doutb !== 128'h11223344_55667788_cafebabe_ddeeff00) begin
         bad++;
         $display("FAIL top_row0_intact doutb=%h expected=%h", doutb, 128'h11223344_55667788_cafebabe_ddeeff00);
      end
   endtask

   task automatic test_collision();
      addrb = 13'd0;
      wea   = 1'b1;
      addra = 15'd0;
      dina  = 32'hdeadbeef;
      tick();
      total++;
      if (doutb !== 128'h11223344_55667788_cafebabe_ddeeff00) begin
         bad++;
         $display("FAIL collision_old doutb=%h expected=%h", doutb, 128'h11223344_55667788_cafebabe_ddeeff00);
      end
      wea = 1'b0;
      tick();
      total++;
      if (doutb[127:96] !== 32'hdeadbeef) begin
         bad++;
         $display("FAIL collision_new doutb_hi=%h expected=%h", doutb[127:96], 32'hdeadbeef);
      end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (doutb !== 128'h0) begin
         bad++;
         $display("FAIL reset_async_clear doutb=%h expected=%h", doutb, 128'h0);
      end
      // A write presented during reset must be dropped.
      wea   = 1'b1;
      addra = 15'd1;
      dina  = 32'h12345678;
      addrb = 13'd0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (doutb !== 128'h0) begin
            bad++;
            $display("FAIL reset_hold cycle=%0d doutb=%h expected=%h", i, doutb, 128'h0);
         end
      end
      wea   = 1'b0;
      rst_n = 1'b1;
      #3;
      total++;
      if (doutb !== 128'h0) begin
         bad++;
         $display("FAIL reset_release_before_edge doutb=%h expected=%h", doutb, 128'h0);
      end
      @(negedge clk);
      tick();
      total++;
      if (doutb !== 128'hdeadbeef_55667788_cafebabe_ddeeff00) begin
         bad++;
         $display("FAIL reset_write_ignored doutb=%h expected=%h", doutb, 128'hdeadbeef_55667788_cafebabe_ddeeff00);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 3000; i++) begin
         wea = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            addra = 15'($urandom_range(0, 63));
            addrb = 13'($urandom_range(0, 15));
         end else begin
            addra = 15'($urandom);
            addrb = 13'($urandom);
         end
         dina = $urandom;
         tick();
         total++;
         if (doutb !== exp_d) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("FAIL random cycle=%0d addrb=%0d doutb=%h expected=%h", i, addrb, doutb, exp_d);
         end
      end
      wea = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Fill one row lane by lane while reading it every cycle.
      addrb = 13'd100;
      wea   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addra = 15'(400 + i);
         dina  = $urandom;
         tick();
         total++;
         if (doutb !== exp_d) begin
            bad++;
            $display("FAIL back_to_back step=%0d doutb=%h expected=%h", i, doutb, exp_d);
         end
      end
      wea = 1'b0;
      tick();
      total++;
      if (doutb !== row_of(13'd100)) begin
         bad++;
         $display("FAIL back_to_back_final doutb=%h expected=%h", doutb, row_of(13'd100));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      clear_mem();
      test_burst();
      test_partial_lane();
      test_wea_low();
      test_top_boundary();
      test_collision();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
